bitstream_decoder: RTL and testbench

- Converts stochastic bitstreams back into binary counts. Each channel counts ones over a fixed window of WINDOW clock cycles.
- Sits downstream of a neuron layer: its stream_in is driven by the layer's per-neuron output bits. It delivers per-channel counts to the readout logic over a valid/ready handshake.
- Supports one-shot and back-to-back (continuous) measurement windows.

---
 rtl/bitstream_decoder.sv | 98 +++++++++
 tb/tb_bitstream_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones per channel over a WINDOW-sample window.
// Latency: result valid on edge WINDOW after the start edge; back-to-back windows have no gap.
// Backpressure: one-deep result register; a new result overwrites an unconsumed one and sets sticky overrun.
module bitstream_decoder #(
   parameter int CHANNELS    = 2,
   parameter int WINDOW      = 256,
   parameter int COUNT_WIDTH = $clog2(WINDOW + 1)
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic [CHANNELS-1:0]             stream_in,
   input  logic                            start,
   input  logic                            continuous,
   output logic [CHANNELS*COUNT_WIDTH-1:0] count_out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy,
   output logic                            overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Sample counter value on the edge that takes the final sample of a window.
   localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE = COUNT_WIDTH'(WINDOW - 1);

   state_t                 state;
   logic [COUNT_WIDTH-1:0] sample_cnt;
   logic [COUNT_WIDTH-1:0] acc [CHANNELS];
   logic                   window_end;

   // Final-sample edge of the current window.
   assign window_end = (state == COUNT) && (sample_cnt == LAST_SAMPLE);

   // busy comes straight from the registered state.
   assign busy = (state == COUNT);

   // Window FSM, per-channel accumulation, result register and handshake.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         count_out  <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i] <= '0;
         end
      end else begin
         // Consumer takes the held result; a result loading below overrides this.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               // stream_in is not sampled on the start edge.
               if (start) begin
                  state      <= COUNT;
                  sample_cnt <= '0;
                  overrun    <= 1'b0;
                  for (int i = 0; i < CHANNELS; i++) begin
                     acc[i] <= '0;
                  end
               end
            end

            COUNT: begin
               if (window_end) begin
                  // Fold the final sample straight into the published count.
                  for (int i = 0; i < CHANNELS; i++) begin
                     count_out[i*COUNT_WIDTH +: COUNT_WIDTH] <= acc[i] + COUNT_WIDTH'(stream_in[i]);
                     acc[i] <= '0;
                  end
                  out_valid  <= 1'b1;
                  sample_cnt <= '0;
                  // Overwriting a result nobody took this edge is an overrun;
                  // a same-edge transfer is not.
                  if (out_valid && !out_ready) begin
                     overrun <= 1'b1;
                  end
                  if (!continuous) begin
                     state <= IDLE;
                  end
               end else begin
                  for (int i = 0; i < CHANNELS; i++) begin
                     acc[i] <= acc[i] + COUNT_WIDTH'(stream_in[i]);
                  end
                  sample_cnt <= sample_cnt + COUNT_WIDTH'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Testbench for bitstream_decoder with WINDOW=8, CHANNELS=2.
// Directed scenarios plus randomized windows against a transaction-level model.
// Model: per-window count is the number of ones; results are one-deep with sticky overrun.
module tb_bitstream_decoder;

   localparam int CH = 2;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic              clk = 1'b0;
   logic              n_rst;
   logic [CH-1:0]     stream_in;
   logic              start;
   logic              continuous;
   logic [CH*CW-1:0]  count_out;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: pending result, sticky overrun, last published counts.
   logic              m_pend;
   logic              m_ovr;
   logic [CW-1:0]     m_cnt [CH];

   bitstream_decoder #(
      .CHANNELS(CH),
      .WINDOW(W),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .stream_in(stream_in),
      .start(start),
      .continuous(continuous),
      .count_out(count_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [CH*CW+2:0] expv(input logic bsy);
      return {m_pend, m_ovr, bsy, m_cnt[1], m_cnt[0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = '0;
   endtask

   // Start edge in IDLE; stream_in is random because it must be ignored.
   task automatic start_win(input logic cont, input logic rdy);
      start      = 1'b1;
      continuous = cont;
      out_ready  = rdy;
      stream_in  = CH'($urandom);
      tick();
      start = 1'b0;
      if (m_pend && rdy) m_pend = 1'b0;
      m_ovr = 1'b0;
      n_checks++;
      if ({out_valid, overrun, busy, count_out} !== expv(1'b1)) begin
         n_fail++;
         $display("FAIL start_edge: got %h expected %h", {out_valid, overrun, busy, count_out}, expv(1'b1));
      end
   endtask

   // Drive one full window; bit k of b0/b1/rdy applies to sample k.
   task automatic run_window(input logic [W-1:0] b0, input logic [W-1:0] b1,
                             input logic [W-1:0] rdy, input logic cont);
      for (int k = 0; k < W; k++) begin
         stream_in  = {b1[k], b0[k]};
         out_ready  = rdy[k];
         continuous = cont;
         tick();
         if (k == W - 1) begin
            if (m_pend && !rdy[k]) m_ovr = 1'b1;
            m_pend   = 1'b1;
            m_cnt[0] = CW'($countones(b0));
            m_cnt[1] = CW'($countones(b1));
         end else if (m_pend && rdy[k]) begin
            m_pend = 1'b0;
         end
         n_checks++;
         if ({out_valid, overrun, busy, count_out} !== expv((k == W - 1) ? cont : 1'b1)) begin
            n_fail++;
            $display("FAIL window_sample%0d: got %h expected %h", k,
                     {out_valid, overrun, busy, count_out}, expv((k == W - 1) ? cont : 1'b1));
         end
      end
   endtask

   // One IDLE cycle with a given out_ready.
   task automatic idle_cycle(input logic rdy);
      stream_in = CH'($urandom);
      out_ready = rdy;
      tick();
      if (m_pend && rdy) m_pend = 1'b0;
      n_checks++;
      if ({out_valid, overrun, busy, count_out} !== expv(1'b0)) begin
         n_fail++;
         $display("FAIL idle_cycle: got %h expected %h", {out_valid, overrun, busy, count_out}, expv(1'b0));
      end
   endtask

   task automatic test_reset();
      n_rst      = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      out_ready  = 1'b0;
      stream_in  = '0;
      model_clear();
      #12;
      n_checks++;
      if ({out_valid, overrun, busy, count_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected 0", {out_valid, overrun, busy, count_out});
      end
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      idle_cycle(1'b0);
   endtask

   task automatic test_one_shot();
      start_win(1'b0, 1'b0);
      run_window('1, '0, '0, 1'b0);
      n_checks++;
      if ({out_valid, busy, count_out} !== {1'b1, 1'b0, 4'd0, 4'd8}) begin
         n_fail++;
         $display("FAIL one_shot_result: got %h expected %h", {out_valid, busy, count_out}, {1'b1, 1'b0, 4'd0, 4'd8});
      end
      idle_cycle(1'b1);
      n_checks++;
      if ({out_valid, count_out} !== {1'b0, 4'd0, 4'd8}) begin
         n_fail++;
         $display("FAIL one_shot_after_transfer: got %h expected %h", {out_valid, count_out}, {1'b0, 4'd0, 4'd8});
      end
   endtask

   task automatic test_last_sample();
      start_win(1'b0, 1'b1);
      run_window(8'b0101_0101, 8'b1000_0000, '0, 1'b0);
      n_checks++;
      if (count_out !== {4'd1, 4'd4}) begin
         n_fail++;
         $display("FAIL last_sample_counted: got %h expected %h", count_out, {4'd1, 4'd4});
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_back_to_back();
      start_win(1'b1, 1'b1);
      run_window('1, 8'h3C, '1, 1'b1);
      n_checks++;
      if ({out_valid, overrun, busy, count_out} !== {1'b1, 1'b0, 1'b1, 4'd4, 4'd8}) begin
         n_fail++;
         $display("FAIL b2b_first: got %h expected %h", {out_valid, overrun, busy, count_out}, {1'b1, 1'b0, 1'b1, 4'd4, 4'd8});
      end
      run_window('0, 8'h01, '1, 1'b0);
      n_checks++;
      if ({out_valid, overrun, count_out} !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
         n_fail++;
         $display("FAIL b2b_second: got %h expected %h", {out_valid, overrun, count_out}, {1'b1, 1'b0, 4'd1, 4'd0});
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_overrun();
      start_win(1'b1, 1'b0);
      run_window(8'hFF, 8'h0F, '0, 1'b1);
      run_window(8'h03, 8'hF0, '0, 1'b0);
      n_checks++;
      if ({overrun, out_valid, count_out} !== {1'b1, 1'b1, 4'd4, 4'd2}) begin
         n_fail++;
         $display("FAIL overrun_set: got %h expected %h", {overrun, out_valid, count_out}, {1'b1, 1'b1, 4'd4, 4'd2});
      end
      idle_cycle(1'b0);
      // Start with a result still pending: overrun clears, result stays valid.
      start_win(1'b0, 1'b0);
      n_checks++;
      if ({overrun, out_valid, count_out} !== {1'b0, 1'b1, 4'd4, 4'd2}) begin
         n_fail++;
         $display("FAIL overrun_cleared_by_start: got %h expected %h", {overrun, out_valid, count_out}, {1'b0, 1'b1, 4'd4, 4'd2});
      end
      run_window(8'h00, 8'hFF, 8'h01, 1'b0);
      idle_cycle(1'b1);
   endtask

   task automatic test_simultaneous();
      start_win(1'b1, 1'b0);
      run_window(8'hAA, 8'h11, '0, 1'b1);
      run_window(8'h07, 8'hFE, 8'h80, 1'b0);
      n_checks++;
      if ({out_valid, overrun, count_out} !== {1'b1, 1'b0, 4'd7, 4'd3}) begin
         n_fail++;
         $display("FAIL simultaneous_transfer_load: got %h expected %h", {out_valid, overrun, count_out}, {1'b1, 1'b0, 4'd7, 4'd3});
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_reset_mid_window();
      start_win(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         stream_in = '1;
         tick();
      end
      #2;
      n_rst = 1'b0;
      model_clear();
      #1;
      n_checks++;
      if ({out_valid, overrun, busy, count_out} !== '0) begin
         n_fail++;
         $display("FAIL mid_window_reset: got %h expected 0", {out_valid, overrun, busy, count_out});
      end
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      idle_cycle(1'b0);
      start_win(1'b0, 1'b0);
      run_window('1, 8'h81, '0, 1'b0);
      n_checks++;
      if (count_out !== {4'd2, 4'd8}) begin
         n_fail++;
         $display("FAIL no_carry_over: got %h expected %h", count_out, {4'd2, 4'd8});
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_random();
      logic in_count;
      logic cont;
      in_count = 1'b0;
      for (int w = 0; w < 16; w++) begin
         if (!in_count) start_win(1'b0, 1'($urandom));
         cont = 1'($urandom);
         run_window(W'($urandom), W'($urandom), W'($urandom), cont);
         in_count = cont;
         if (!cont) begin
            repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom));
         end
      end
      if (in_count) run_window(W'($urandom), W'($urandom), W'($urandom), 1'b0);
      idle_cycle(1'b1);
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_last_sample();
      test_back_to_back();
      test_overrun();
      test_simultaneous();
      test_reset_mid_window();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
